// File: rtl/timer_pkg.sv
// Shared definitions for the timer subsystem: status encodings, field widths
// and the seconds saturation helper used by both countdown and stopwatch.
package timer_pkg;

  localparam int unsigned MIN_W   = 8;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned SEC_MAX = 59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } status_e;

  function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : s;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a timer and its controller/display path.
interface countdown_timer_if;
  import timer_pkg::*;

  logic             start;
  logic             stop;
  logic             reset;
  logic             load;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic [1:0]       status;
  logic             done;

  modport master (
    output start, stop, reset, load, load_min, load_sec,
    input  minutes, seconds, status, done
  );

  modport slave (
    input  start, stop, reset, load, load_min, load_sec,
    output minutes, seconds, status, done
  );
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles;
// holds its count while disabled, clr has priority over en.
module tick_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/countdown_timer.sv
// Preset minutes:seconds countdown with start/stop/reset/load pulses,
// 2-bit status and a single-cycle done pulse on expiry.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    countdown_timer_if.slave   bus
);

    status_e          state;
    logic [MIN_W-1:0] min_q, preset_min;
    logic [SEC_W-1:0] sec_q, preset_sec;
    logic             done_q;
    logic             tick;
    logic             presc_en, presc_clr;
    logic             load_take;

    // Prescaler idles at zero outside RUNNING/PAUSED, so a start from IDLE begins a fresh second.
    assign presc_en  = (state == ST_RUNNING);
    assign presc_clr = bus.reset || (state == ST_IDLE) || (state == ST_EXPIRED);
    assign load_take = bus.load && (state != ST_RUNNING);

    tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            min_q      <= '0;
            sec_q      <= '0;
            preset_min <= '0;
            preset_sec <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.reset) begin
                state <= ST_IDLE;
                min_q <= preset_min;
                sec_q <= preset_sec;
            end else if (load_take) begin
                preset_min <= bus.load_min;
                preset_sec <= sat_sec(bus.load_sec);
                min_q      <= bus.load_min;
                sec_q      <= sat_sec(bus.load_sec);
                if (state != ST_PAUSED) state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start && (min_q != '0 || sec_q != '0)) state <= ST_RUNNING;
                    end
                    ST_RUNNING: begin
                        if (bus.stop) begin
                            state <= ST_PAUSED;
                        end else if (tick) begin
                            // Also catches a run resumed at 00:00 after a paused load of zero.
                            if (min_q == '0 && sec_q <= SEC_W'(1)) begin
                                sec_q  <= '0;
                                state  <= ST_EXPIRED;
                                done_q <= 1'b1;
                            end else if (sec_q != '0) begin
                                sec_q <= sec_q - 1'b1;
                            end else begin
                                min_q <= min_q - 1'b1;
                                sec_q <= SEC_W'(SEC_MAX);
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (bus.start && !bus.stop) state <= ST_RUNNING;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.minutes = min_q;
    assign bus.seconds = sec_q;
    assign bus.status  = state;
    assign bus.done    = done_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Count-down companion to the stopwatch: preset minutes:seconds, decrement once per second tick, flag expiry.
Same control style as the stopwatch: single-cycle start/stop/reset pulses and a 2-bit status.
Sits beside the stopwatch in the timer subsystem and drives the same display/status path.

Parameters:
TICKS_PER_SEC, 1, clk cycles per one-second decrement; 1 in simulation, board clock rate in synthesis; must be >= 1.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: begin or resume countdown
stop  input  1  single-cycle pulse: pause countdown
reset  input  1  single-cycle pulse: functional reset, restore preset
load  input  1  single-cycle pulse: capture load_min/load_sec as preset
load_min  input  8  preset minutes, 0..255
load_sec  input  6  preset seconds; values above 59 saturate to 59
minutes  output  8  current remaining minutes
seconds  output  6  current remaining seconds, 0..59
status  output  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
done  output  1  one-cycle pulse on expiry

Behaviour:
- rst_n low (async): minutes=0, seconds=0, preset=00:00, status=IDLE, done=0, prescaler=0.
- All outputs registered. A control pulse sampled at edge N is visible after edge N.
- Input priority within a cycle: reset > load > stop > start.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only while RUNNING.
  - Held while PAUSED.
  - Cleared on any entry to IDLE and on start from IDLE.
  - tick = prescaler at max while RUNNING. TICKS_PER_SEC=1 gives a tick every RUNNING cycle.
- States and transitions:
  - IDLE: start with value != 00:00 -> RUNNING. start with 00:00 is ignored (stays IDLE). stop is ignored.
  - RUNNING:
    - stop -> PAUSED; a tick in the same cycle is discarded.
    - start is ignored.
    - On a tick: seconds>0 -> seconds-1. seconds==0 and minutes>0 -> minutes-1, seconds=59.
    - A tick that yields 00:00 -> EXPIRED, with done=1 in the same cycle status first reads 11.
  - PAUSED: start -> RUNNING, prescaler resumes from its held value. Simultaneous start and stop keeps PAUSED.
  - EXPIRED: minutes/seconds hold 00:00. start and stop are ignored.
  - done is high for exactly one cycle per expiry, never re-asserted while holding EXPIRED.
- load:
  - Ignored in RUNNING.
  - In IDLE or EXPIRED: preset and minutes/seconds take the load value, status -> IDLE.
  - In PAUSED: preset and minutes/seconds take the load value, status stays PAUSED.
- reset (any state): status -> IDLE, minutes/seconds = preset, prescaler=0, done=0.
- Maximum value 255:59. No wrap below 00:00; the value is never decremented past zero.
- rst_n asserted mid-count clears everything immediately, including the preset.

Decomposition:
- Shared package timer_pkg holds:
  - status encodings ST_IDLE, ST_RUNNING, ST_PAUSED, ST_EXPIRED
  - SEC_MAX=59
  - MIN_W=8, SEC_W=6
- The stopwatch adopts the same encodings.
- One sub-module: tick_prescaler.
  - Parameter TICKS_PER_SEC.
  - Inputs: en, clr.
  - Output: tick.
  - Reusable by the stopwatch.

Test Plan (TICKS_PER_SEC=1 unless noted):
1. load 00:03, start -> seconds 2,1,0 on successive cycles. status=11 and done=1 for one cycle when 00:00 is reached. done=0 thereafter while status holds 11.
2. load 01:00, start -> next tick gives 00:59, then 00:58. Run to expiry: done pulses once after 60 ticks.
3. load 00:10, start, 4 ticks -> 00:06. stop, hold 10 cycles -> stays 00:06, status=10. start, 6 ticks -> 00:00, status=11.
4. load 02:30, start, 5 ticks -> 02:25. reset -> 02:30, status=00. start again -> counts from 02:30.
5. Boundaries:
   - load_sec=63 -> seconds=59.
   - start at 00:00 -> status stays 00.
   - load 05:00 while RUNNING -> ignored.
   - start+stop in the same cycle while PAUSED -> stays 10.
   - reset+load in the same cycle -> reset wins.
6. TICKS_PER_SEC=4: load 00:02, start -> decrement every 4 cycles, expiry after 8. Then rst_n low mid-run -> 00:00, status=00, preset cleared (a following reset gives 00:00).
